// File: rtl/interp_pkg.sv
// Shared constants and helpers for the interpolator cascade.
package interp_pkg;

  // Reciprocal of the ratio in FRAC fractional bits, rounded half up.
  function automatic int unsigned recip_f(input int unsigned ratio, input int unsigned frac);
    return ((32'd1 << frac) + ratio / 2) / ratio;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  // Extends a w-bit sample to 64 bits, sign-extending when sgn is set.
  function automatic logic [63:0] ext_f(input logic [63:0] v, input int unsigned w,
                                        input logic sgn);
    logic [63:0] r;
    for (int unsigned i = 0; i < 64; i++) begin
      r[6'(i)] = (i < w) ? v[6'(i)] : (sgn & v[6'(w - 1)]);
    end
    return r;
  endfunction

endpackage

// File: rtl/interp_stage.sv
// One interpolation stage: holds a segment (x0 -> x1) and emits RATIO points per segment.
module interp_stage
  import interp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RATIO  = 10,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned LANES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seg_start_i,
  input  logic                     step_i,
  input  logic                     mode_i,
  input  logic [LANES*WIDTH-1:0]   x_i,
  output logic [LANES*WIDTH-1:0]   y_o
);

  localparam int unsigned KW = cnt_w_f(RATIO);
  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned PW = DW + KW + 1 + FRAC + 1;
  localparam logic [FRAC-1:0] RECIP = FRAC'(recip_f(RATIO, FRAC));
  localparam logic signed [PW-1:0] HALF = PW'(64'd1 << (FRAC - 1));

  logic [LANES-1:0][WIDTH-1:0] x0_q, x0_d;
  logic [LANES-1:0][WIDTH-1:0] x1_q, x1_d;
  logic [LANES-1:0][WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]               k_q, k_d;
  logic                        m_q, m_d;

  // x0 + round(k * (x1 - x0) / RATIO), evaluated at full product width.
  function automatic logic [WIDTH-1:0] lerp_f(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [KW-1:0] k);
    logic signed [PW-1:0] ea, eb, pd, pk, pr, acc;
    logic signed [DW-1:0] diff;
    ea   = $signed(PW'(ext_f(64'(a), WIDTH, SIGNED != 0)));
    eb   = $signed(PW'(ext_f(64'(b), WIDTH, SIGNED != 0)));
    diff = DW'(eb - ea);
    pd   = {{(PW - DW){diff[DW-1]}}, diff};
    pk   = PW'({1'b0, k});
    pr   = PW'({1'b0, RECIP});
    acc  = pd * pk * pr + HALF;
    acc  = acc >>> FRAC;
    return WIDTH'(ea + acc);
  endfunction

  always_comb begin
    x0_d = x0_q;
    x1_d = x1_q;
    k_d  = k_q;
    m_d  = m_q;
    y_d  = y_q;
    if (seg_start_i) begin
      x0_d = x1_q;
      x1_d = x_i;
      k_d  = '0;
      m_d  = mode_i;
    end else if (step_i) begin
      k_d = k_q + KW'(1);
    end
    // Output uses the segment state as it stands after this cycle's update.
    if (step_i) begin
      for (int l = 0; l < int'(LANES); l++) begin
        y_d[l] = m_d ? lerp_f(x0_d[l], x1_d[l], k_d) : x0_d[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0;
      x1_q <= '0;
      y_q  <= '0;
      k_q  <= '0;
      m_q  <= 1'b0;
    end else begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      y_q  <= y_d;
      k_q  <= k_d;
      m_q  <= m_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/interp_cascade.sv
// Multi-stage linear/hold interpolator raising the sample rate by RATIO^NSTAGES.
module interp_cascade
  import interp_pkg::*;
#(
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned RATIO   = 10,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LANES   = 1,
  parameter int unsigned SIGNED  = 0,
  parameter int unsigned FRAC    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSTAGES-1:0]     mode,
  input  logic [LANES*WIDTH-1:0] sample_in,
  output logic                   in_strobe,
  output logic [NSTAGES-1:0]     stage_strobe,
  output logic [LANES*WIDTH-1:0] sample_out
);

  localparam int unsigned CW = cnt_w_f(RATIO);

  logic [NSTAGES-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NSTAGES:0]           en_c;
  logic [LANES*WIDTH-1:0]     chain [NSTAGES+1];

  // Strobe chain: stage s fires when its counter and every faster one sit at zero.
  always_comb begin
    en_c          = '0;
    en_c[NSTAGES] = ~rst;
    for (int s = int'(NSTAGES) - 1; s >= 0; s--) begin
      en_c[s] = en_c[s+1] & (cnt_q[s] == '0);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int s = 0; s < int'(NSTAGES); s++) begin
      if (en_c[s+1]) begin
        cnt_d[s] = (cnt_q[s] == CW'(RATIO - 1)) ? '0 : cnt_q[s] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_strobe    = en_c[0];
  assign stage_strobe = en_c[NSTAGES-1:0];
  assign chain[0]     = sample_in;

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    interp_stage #(
      .WIDTH (WIDTH),
      .RATIO (RATIO),
      .SIGNED(SIGNED),
      .FRAC  (FRAC),
      .LANES (LANES)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .seg_start_i(en_c[s]),
      .step_i     (en_c[s+1]),
      .mode_i     (mode[s]),
      .x_i        (chain[s]),
      .y_o        (chain[s+1])
    );
  end

  assign sample_out = chain[NSTAGES];

endmodule

// File: tb/tb_interp_cascade.sv
// Directed bench for interp_cascade: four configurations run side by side on one clock.
module tb_interp_cascade;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int   t = -1;
  int   nvec = 0;
  int   nerr = 0;

  // a: N=1 R=10 linear unsigned
  logic       mode1;
  logic [7:0] din1, out1;
  logic       istb1;
  logic [0:0] sstb1;
  // b: N=2 R=4 hold
  logic [1:0] mode2;
  logic [7:0] din2, out2;
  logic       istb2;
  logic [1:0] sstb2;
  // c: N=3 R=10 linear DC
  logic [2:0] mode3;
  logic [7:0] din3, out3;
  logic       istb3;
  logic [2:0] sstb3;
  // s: N=1 R=4 signed two lanes
  logic        mode4;
  logic [15:0] din4, out4;
  logic        istb4;
  logic [0:0]  sstb4;

  interp_cascade #(.NSTAGES(1), .RATIO(10), .WIDTH(8), .LANES(1), .SIGNED(0), .FRAC(16)) u_a (
    .clk(clk), .rst(rst1), .mode(mode1), .sample_in(din1),
    .in_strobe(istb1), .stage_strobe(sstb1), .sample_out(out1));

  interp_cascade #(.NSTAGES(2), .RATIO(4), .WIDTH(8), .LANES(1), .SIGNED(0), .FRAC(16)) u_b (
    .clk(clk), .rst(rst0), .mode(mode2), .sample_in(din2),
    .in_strobe(istb2), .stage_strobe(sstb2), .sample_out(out2));

  interp_cascade #(.NSTAGES(3), .RATIO(10), .WIDTH(8), .LANES(1), .SIGNED(0), .FRAC(16)) u_c (
    .clk(clk), .rst(rst0), .mode(mode3), .sample_in(din3),
    .in_strobe(istb3), .stage_strobe(sstb3), .sample_out(out3));

  interp_cascade #(.NSTAGES(1), .RATIO(4), .WIDTH(8), .LANES(2), .SIGNED(1), .FRAC(16)) u_s (
    .clk(clk), .rst(rst0), .mode(mode4), .sample_in(din4),
    .in_strobe(istb4), .stage_strobe(sstb4), .sample_out(out4));

  typedef struct {
    logic [7:0]  din_a;
    logic [7:0]  exp_a;
    logic        stb_a;
    logic [7:0]  din_b;
    logic [7:0]  exp_b;
    logic [15:0] din_s;
    logic [15:0] exp_s;
    logic        chk_s;
  } vec_t;

  localparam int NV = 61;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic check_c();
    chk("c_strobes", 32'({istb3, sstb3}),
        32'({t % 1000 == 0, t % 10 == 0, t % 100 == 0, t % 1000 == 0}));
    if (t >= 2500) chk("c_dc", 32'(out3), 32'h5A);
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
    #1;
    check_c();
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      vecs[i].din_a = (i >= 10 && i < 30) ? 8'd100 : 8'd0;
      if (i <= 11)      vecs[i].exp_a = 8'd0;
      else if (i <= 20) vecs[i].exp_a = 8'(10 * (i - 11));
      else if (i <= 31) vecs[i].exp_a = 8'd100;
      else if (i <= 40) vecs[i].exp_a = 8'(100 - 10 * (i - 31));
      else              vecs[i].exp_a = 8'd0;
      vecs[i].stb_a = (i % 10 == 0);
      vecs[i].din_b = (i < 16) ? 8'h10 : 8'h80;
      if (i <= 24)      vecs[i].exp_b = 8'h00;
      else if (i <= 40) vecs[i].exp_b = 8'h10;
      else              vecs[i].exp_b = 8'h80;
      vecs[i].din_s = (i < 4) ? 16'h7F80 : 16'h807F;
      case (i)
        0:       vecs[i].exp_s = 16'h0000;
        5:       vecs[i].exp_s = 16'h7F80;
        6:       vecs[i].exp_s = 16'h3FC0;
        7:       vecs[i].exp_s = 16'h0000;
        8:       vecs[i].exp_s = 16'hC03F;
        default: vecs[i].exp_s = 16'h807F;
      endcase
      vecs[i].chk_s = (i == 0 || i >= 5);
    end

    rst0 = 1'b1; rst1 = 1'b1;
    mode1 = 1'b1; mode2 = 2'b00; mode3 = 3'b111; mode4 = 1'b1;
    din1 = vecs[0].din_a; din2 = vecs[0].din_b; din3 = 8'h5A; din4 = vecs[0].din_s;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobe_a", 32'({istb1, sstb1}), 32'h0);
    chk("rst_strobe_c", 32'({istb3, sstb3}), 32'h0);

    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; t = 0;
    #1;
    check_c();

    for (int i = 0; i < NV; i++) begin
      if (i > 0) tick();
      din1 = vecs[i].din_a;
      din2 = vecs[i].din_b;
      din4 = vecs[i].din_s;
      chk("a_out", 32'(out1), 32'(vecs[i].exp_a));
      chk("a_strobe", 32'(istb1), 32'(vecs[i].stb_a));
      chk("b_out", 32'(out2), 32'(vecs[i].exp_b));
      if (vecs[i].chk_s) chk("s_out", 32'(out4), 32'(vecs[i].exp_s));
    end

    // Mid-segment mode change is ignored; mid-segment reset clears everything.
    while (t < 70) tick();
    chk("a_seg_strobe", 32'(istb1), 32'd1);
    din1 = 8'd200;
    tick(); chk("a_ramp0", 32'(out1), 32'd0);
    tick(); chk("a_ramp1", 32'(out1), 32'd20);
    tick(); chk("a_ramp2", 32'(out1), 32'd40);
    mode1 = 1'b0;
    tick(); chk("a_mode_ignored3", 32'(out1), 32'd60);
    tick(); chk("a_mode_ignored4", 32'(out1), 32'd80);
    tick(); chk("a_mode_ignored5", 32'(out1), 32'd100);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    #1;
    chk("a_post_rst_out", 32'(out1), 32'd0);
    chk("a_post_rst_strobe", 32'(istb1), 32'd1);
    tick(); chk("a_hold_after_rst", 32'(out1), 32'd0);
    while (t < 87) tick();
    chk("a_strobe_after_rst", 32'(istb1), 32'd1);
    chk("a_hold_pre", 32'(out1), 32'd0);
    tick(); chk("a_hold_step", 32'(out1), 32'd200);

    while (t < 3100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
